uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (UART_TX, 115200 baud @ 50 MHz) among up to N on-board requesters, e.g. button-report packetizer, debug/status reporter and config echo.
- Arbitrates round-robin at packet granularity: one requester owns the TX from its first byte until its LAST byte completes.
- Sequences each byte into the transmitter via the DV/ACTIVE/DONE handshake and enforces a minimum inter-byte idle gap.
- A watchdog aborts a stalled packet.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_select.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM states and default timing.
package uart_tx_arbiter_pkg;

   // One bit time at 115200 baud from a 50 MHz clock
   localparam int unsigned c_CYCLES_PER_BIT  = 434;
   localparam int unsigned c_NUM_REQ_DEFAULT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_ACTIVE,
      ST_WAIT_DONE,
      ST_GAP,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first set request strictly after the pointer, wrapping.
module rr_priority_select #(
   parameter int unsigned c_WIDTH = 4
) (
   input  logic [c_WIDTH-1:0]         req,
   input  logic [$clog2(c_WIDTH)-1:0] ptr,
   output logic [c_WIDTH-1:0]         winner,
   output logic [$clog2(c_WIDTH)-1:0] winner_idx,
   output logic                       valid
);

   localparam int unsigned IW = $clog2(c_WIDTH);

   logic [IW-1:0] idx;

   // Scan from ptr+1 around to ptr itself; the first hit wins
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      valid      = 1'b0;
      idx        = '0;
      for (int unsigned i = 1; i <= c_WIDTH; i++) begin
         idx = IW'((32'(ptr) + i) % c_WIDTH);
         if (!valid && req[idx]) begin
            valid       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among requesters.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned c_NUM_REQ        = c_NUM_REQ_DEFAULT,
   parameter int unsigned c_GAP_CYCLES     = c_CYCLES_PER_BIT,
   parameter int unsigned c_TIMEOUT_CYCLES = 10000
) (
   input  logic                   i_CLK,
   input  logic                   i_RESET,
   input  logic [c_NUM_REQ-1:0]   i_REQ,
   input  logic [8*c_NUM_REQ-1:0] i_REQ_DATA,
   input  logic [c_NUM_REQ-1:0]   i_REQ_LAST,
   output logic [c_NUM_REQ-1:0]   o_REQ_ACK,
   output logic [c_NUM_REQ-1:0]   o_GRANT,
   output logic                   o_TX_DV,
   output logic [7:0]             o_TX_BYTE,
   input  logic                   i_TX_ACTIVE,
   input  logic                   i_TX_DONE,
   output logic                   o_BUSY,
   output logic                   o_ERR
);

   localparam int unsigned IW = $clog2(c_NUM_REQ);
   localparam int unsigned GW = $clog2(c_GAP_CYCLES) + 1;
   localparam int unsigned TW = $clog2(c_TIMEOUT_CYCLES) + 1;

   state_t state_q, state_d;

   logic [IW-1:0]        ptr_q;
   logic [c_NUM_REQ-1:0] grant_q;
   logic [c_NUM_REQ-1:0] ack_q, ack_d;
   logic [7:0]           tx_byte_q;
   logic                 tx_dv_q, dv_d;
   logic                 err_q, err_d;
   logic                 last_q;
   logic [GW-1:0]        gap_cnt_q;
   logic [TW-1:0]        wd_cnt_q;
   logic                 gap_end, wd_end, abort;

   logic [c_NUM_REQ-1:0] pick;
   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;

   rr_priority_select #(
      .c_WIDTH (c_NUM_REQ)
   ) u_rr (
      .req        (i_REQ),
      .ptr        (ptr_q),
      .winner     (pick),
      .winner_idx (pick_idx),
      .valid      (pick_valid)
   );

   assign gap_end = (gap_cnt_q == GW'(c_GAP_CYCLES - 1));
   assign wd_end  = (wd_cnt_q == TW'(c_TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic, including watchdog abort from the wait states
   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      case (state_q)
         ST_IDLE: if (pick_valid) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_WAIT_ACTIVE;
         ST_WAIT_ACTIVE: begin
            if (i_TX_DONE)        state_d = ST_GAP;
            else if (i_TX_ACTIVE) state_d = ST_WAIT_DONE;
            else if (wd_end) begin
               state_d = ST_IDLE;
               abort   = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (i_TX_DONE) state_d = ST_GAP;
            else if (wd_end) begin
               state_d = ST_IDLE;
               abort   = 1'b1;
            end
         end
         ST_GAP: if (gap_end) state_d = last_q ? ST_IDLE : ST_HOLD;
         ST_HOLD: begin
            if (|(i_REQ & grant_q)) state_d = ST_LOAD;
            else if (wd_end) begin
               state_d = ST_IDLE;
               abort   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode; DV/ACK/ERR are registered below so they rise the cycle after LOAD/abort
   always_comb begin
      dv_d   = (state_q == ST_LOAD);
      ack_d  = dv_d ? grant_q : '0;
      err_d  = abort;
      o_BUSY = (state_q != ST_IDLE);
   end

   // Grant, pointer, byte latch, pulse outputs and the gap/watchdog counters
   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         ptr_q     <= IW'(c_NUM_REQ - 1);
         grant_q   <= '0;
         ack_q     <= '0;
         tx_byte_q <= '0;
         tx_dv_q   <= 1'b0;
         err_q     <= 1'b0;
         last_q    <= 1'b0;
         gap_cnt_q <= '0;
         wd_cnt_q  <= '0;
      end else begin
         tx_dv_q <= dv_d;
         ack_q   <= ack_d;
         err_q   <= err_d;

         if (state_q == ST_IDLE && pick_valid) begin
            grant_q <= pick;
            ptr_q   <= pick_idx;
         end else if (state_d == ST_IDLE) begin
            grant_q <= '0;
         end

         // ptr_q holds the owner index for the whole packet, so it selects the byte lane
         if (state_q == ST_LOAD) begin
            tx_byte_q <= i_REQ_DATA[{ptr_q, 3'b000} +: 8];
            last_q    <= i_REQ_LAST[ptr_q];
         end

         if (state_d != state_q) begin
            gap_cnt_q <= '0;
            wd_cnt_q  <= '0;
         end else begin
            if (state_q == ST_GAP) gap_cnt_q <= gap_cnt_q + 1'b1;
            if (state_q == ST_WAIT_ACTIVE || state_q == ST_WAIT_DONE || state_q == ST_HOLD)
               wd_cnt_q <= wd_cnt_q + 1'b1;
         end
      end
   end

   assign o_GRANT   = grant_q;
   assign o_REQ_ACK = ack_q;
   assign o_TX_DV   = tx_dv_q;
   assign o_TX_BYTE = tx_byte_q;
   assign o_ERR     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: packet-level round-robin reference model plus a behavioural UART_TX.
module tb_uart_tx_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned G    = 20;
   localparam int unsigned T    = 600;
   localparam int unsigned MAXB = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   ack, grant;
   logic           tx_dv, tx_active, tx_done, busy, err;
   logic [7:0]     tx_byte;

   uart_tx_arbiter #(
      .c_NUM_REQ        (N),
      .c_GAP_CYCLES     (G),
      .c_TIMEOUT_CYCLES (T)
   ) dut (
      .i_CLK       (clk),
      .i_RESET     (rst_n),
      .i_REQ       (req),
      .i_REQ_DATA  (req_data),
      .i_REQ_LAST  (req_last),
      .o_REQ_ACK   (ack),
      .o_GRANT     (grant),
      .o_TX_DV     (tx_dv),
      .o_TX_BYTE   (tx_byte),
      .i_TX_ACTIVE (tx_active),
      .i_TX_DONE   (tx_done),
      .o_BUSY      (busy),
      .o_ERR       (err)
   );

   initial forever #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Requester scripts: {last, byte} per entry
   logic [8:0]  mem [N][MAXB];
   int unsigned n_bytes [N];
   int unsigned pos [N];
   int unsigned start_dly [N];
   int unsigned stall_fix [N];
   int unsigned stall_left [N];
   int unsigned stall_max;
   bit          drv_en = 0;
   int unsigned scn_cyc = 0;

   typedef struct {
      int unsigned who;
      logic [7:0]  b;
   } exp_t;
   exp_t        exp_q[$];
   int unsigned model_ptr = N - 1;

   int unsigned cyc = 0;
   int unsigned last_done_cyc = 0;
   bit          done_valid = 0;
   bit          hang = 0;
   int unsigned err_cnt = 0;

   initial forever @(posedge clk) cyc++;
   initial forever begin
      @(negedge clk);
      if (err === 1'b1) err_cnt++;
   end

   // Reference: whole packets granted in round-robin order after the previous owner
   function automatic void build_expected();
      int unsigned cur [N];
      int unsigned p;
      int          w;
      bit          first;
      bit          fin;
      for (int k = 0; k < N; k++) cur[k] = 0;
      p = model_ptr;
      first = 1;
      exp_q.delete();
      while (1) begin
         w = -1;
         for (int unsigned i = 1; i <= N; i++) begin
            int unsigned k;
            k = (p + i) % N;
            if (w < 0 && cur[k] < n_bytes[k] && (!first || start_dly[k] == 0)) w = int'(k);
         end
         if (w < 0) break;
         fin = 0;
         while (!fin && cur[w] < n_bytes[w]) begin
            exp_q.push_back('{who: w, b: mem[w][cur[w]][7:0]});
            fin = mem[w][cur[w]][8];
            cur[w]++;
         end
         p = w;
         first = 0;
      end
      model_ptr = p;
   endfunction

   task automatic clear_pkts();
      for (int k = 0; k < N; k++) begin
         n_bytes[k] = 0; start_dly[k] = 0; stall_fix[k] = 0;
      end
      stall_max = 0;
   endtask

   task automatic add_byte(input int unsigned k, input logic [7:0] b, input bit last);
      mem[k][n_bytes[k]] = {last, b};
      n_bytes[k]++;
   endtask

   // Requester behaviour: present the current byte, advance on ACK, optional stall inside a packet
   initial begin
      int unsigned idx;
      req = '0; req_data = '0; req_last = '0;
      for (int k = 0; k < N; k++) begin
         n_bytes[k] = 0; pos[k] = 0; stall_left[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (drv_en) begin
               if (ack[k] && pos[k] < n_bytes[k]) begin
                  if (!mem[k][pos[k]][8])
                     stall_left[k] = (stall_fix[k] != 0) ? stall_fix[k] : $urandom_range(stall_max, 0);
                  pos[k]++;
               end else if (stall_left[k] != 0) begin
                  stall_left[k]--;
               end
            end
            req[k] = drv_en && scn_cyc >= start_dly[k] && pos[k] < n_bytes[k] && stall_left[k] == 0;
            idx = (pos[k] < MAXB) ? pos[k] : 0;
            req_data[8*k +: 8] = mem[k][idx][7:0];
            req_last[k] = mem[k][idx][8];
         end
         if (drv_en) scn_cyc++;
      end
   end

   // UART_TX stand-in: checks each DV against the reference, then runs a short frame
   initial begin
      exp_t        e;
      int unsigned len, cnt;
      bit          hold;
      tx_active = 1'b0; tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (tx_dv === 1'b1) begin
            check_eq("dv_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("owner", grant, 32'd1 << e.who);
               check_eq("ack", ack, 32'd1 << e.who);
               check_eq("byte", tx_byte, e.b);
            end
            if (done_valid) check_eq("gap_min", (cyc - last_done_cyc) >= G + 1, 1);
            done_valid = 0;
            hold = hang;
            tx_active = 1'b1;
            cnt = 1;
            @(negedge clk);
            check_eq("dv_width", tx_dv, 0);
            if (hold) begin
               while (!err && rst_n && cnt < T + 50) begin
                  @(negedge clk);
                  cnt++;
               end
               if (!rst_n) begin
                  tx_active = 1'b0;
               end else begin
                  check_eq("wd_seen", err, 1);
                  check_eq("wd_time", cnt, T + 1);
                  check_eq("wd_grant_clr", grant, 0);
                  tx_active = 1'b0;
                  @(negedge clk);
                  check_eq("wd_regrant", grant, (exp_q.size() != 0) ? (32'd1 << exp_q[0].who) : 32'd0);
               end
               hang = 0;
            end else begin
               len = $urandom_range(30, 5);
               repeat (len - 1) @(negedge clk);
               tx_active = 1'b0;
               tx_done = 1'b1;
               last_done_cyc = cyc;
               done_valid = 1;
            end
         end
      end
   end

   task automatic start_scn();
      build_expected();
      done_valid = 0;
      err_cnt = 0;
      for (int k = 0; k < N; k++) begin
         pos[k] = 0; stall_left[k] = 0;
      end
      scn_cyc = 0;
      drv_en = 1;
   endtask

   task automatic run_scn(input int unsigned exp_err);
      int unsigned guard;
      bit          sent;
      start_scn();
      guard = 0;
      sent = 0;
      while (!(sent && exp_q.size() == 0 && !busy) && guard < 40000) begin
         @(negedge clk);
         guard++;
         sent = 1;
         for (int k = 0; k < N; k++) if (pos[k] < n_bytes[k]) sent = 0;
      end
      check_eq("scn_complete", guard < 40000, 1);
      repeat (2) @(negedge clk);
      check_eq("idle_grant", grant, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("err_count", err_cnt, exp_err);
      drv_en = 0;
      @(negedge clk);
   endtask

   initial begin
      int unsigned guard, np, nb, total;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #20;
      check_eq("rst_grant", grant, 0);
      check_eq("rst_dv", tx_dv, 0);
      check_eq("rst_byte", tx_byte, 0);
      check_eq("rst_ack", ack, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single two-byte packet from requester 0
      clear_pkts();
      add_byte(0, 8'h27, 0);
      add_byte(0, 8'hA5, 1);
      run_scn(0);

      // Three simultaneous single-byte packets, then again with the pointer parked on 1
      clear_pkts();
      for (int k = 0; k < 3; k++) add_byte(k, 8'h40 + 8'(k), 1);
      run_scn(0);
      clear_pkts();
      add_byte(1, 8'h99, 1);
      run_scn(0);
      clear_pkts();
      for (int k = 0; k < 3; k++) add_byte(k, 8'h50 + 8'(k), 1);
      run_scn(0);

      // Late request from requester 1 must wait for requester 0's whole packet
      clear_pkts();
      add_byte(0, 8'h01, 0);
      add_byte(0, 8'h02, 0);
      add_byte(0, 8'h03, 1);
      add_byte(1, 8'h77, 1);
      start_dly[1] = 10;
      run_scn(0);

      // Long stall inside a packet stays under the watchdog
      clear_pkts();
      add_byte(0, 8'h11, 0);
      add_byte(0, 8'h3C, 1);
      stall_fix[0] = 500;
      run_scn(0);

      // Transmitter never completes: watchdog aborts, next requester gets the grant
      clear_pkts();
      add_byte(0, 8'hE1, 1);
      add_byte(1, 8'hE2, 1);
      start_dly[1] = 5;
      hang = 1;
      run_scn(1);

      // Asynchronous reset while waiting for DONE
      clear_pkts();
      add_byte(0, 8'h5A, 1);
      hang = 1;
      start_scn();
      guard = 0;
      while (!tx_active && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_eq("pre_rst_active", tx_active, 1);
      repeat (2) @(negedge clk);
      check_eq("pre_rst_byte", tx_byte, 8'h5A);
      check_eq("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_grant", grant, 0);
      check_eq("arst_dv", tx_dv, 0);
      check_eq("arst_byte", tx_byte, 0);
      check_eq("arst_ack", ack, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_err", err, 0);
      drv_en = 0;
      clear_pkts();
      exp_q.delete();
      model_ptr = N - 1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) add_byte(k, 8'h60 + 8'(k), 1);
      run_scn(0);

      // Randomized traffic
      for (int r = 0; r < 20; r++) begin
         clear_pkts();
         stall_max = 40;
         total = 0;
         for (int k = 0; k < N; k++) begin
            np = $urandom_range(3, 0);
            for (int p = 0; p < int'(np); p++) begin
               nb = $urandom_range(4, 1);
               for (int b = 0; b < int'(nb); b++) add_byte(k, 8'($urandom), b == int'(nb) - 1);
               total += nb;
            end
         end
         if (total == 0) add_byte(0, 8'($urandom), 1);
         run_scn(0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
